// File: rtl/hazard_control_unit_if.sv
// Bundle of the pipeline-side signals seen by the hazard control unit.
// The pipeline (master) drives register addresses and memory handshake; the unit (slave) returns controls.
interface hazard_control_unit_if;
    logic [4:0] RS1_D;
    logic [4:0] RS2_D;
    logic [4:0] RS1_E;
    logic [4:0] RS2_E;
    logic [4:0] RD_E;
    logic [1:0] Result_Src_Sel_E;
    logic       PC_Src_Sel_E;
    logic [4:0] RD_M;
    logic       REG_W_En_M;
    logic [4:0] RD_W;
    logic       REG_W_En_W;
    logic       MEM_Req_M;
    logic       MEM_Ready;
    logic       Stall_F;
    logic       Stall_D;
    logic       Stall_E;
    logic       Stall_M;
    logic       Flush_D;
    logic       Flush_E;
    logic       Flush_W;
    logic [1:0] Forward_A_E;
    logic [1:0] Forward_B_E;
    logic       Mem_Timeout;

    modport master (
        output RS1_D, RS2_D, RS1_E, RS2_E, RD_E, Result_Src_Sel_E, PC_Src_Sel_E,
               RD_M, REG_W_En_M, RD_W, REG_W_En_W, MEM_Req_M, MEM_Ready,
        input  Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W,
               Forward_A_E, Forward_B_E, Mem_Timeout
    );

    modport slave (
        input  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, Result_Src_Sel_E, PC_Src_Sel_E,
               RD_M, REG_W_En_M, RD_W, REG_W_En_W, MEM_Req_M, MEM_Ready,
        output Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W,
               Forward_A_E, Forward_B_E, Mem_Timeout
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Stall/flush sequencing and operand forwarding for a five-stage RV32i pipeline,
// including post-reset drain and multi-cycle data-memory waits with a sticky timeout.
module hazard_control_unit #(
    parameter int RESET_DRAIN_CYCLES = 2,
    parameter int MAX_WAIT_CYCLES    = 16
) (
    input logic                 CLK,
    input logic                 RST,
    hazard_control_unit_if.slave hz
);
    localparam int WW = $clog2(MAX_WAIT_CYCLES + 1);
    localparam logic [3:0]    DRAIN_LAST = 4'(RESET_DRAIN_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_MAX   = WW'(MAX_WAIT_CYCLES);

    typedef enum logic [1:0] {DRAIN, RUN, MEM_WAIT} state_t;

    state_t        state, state_next;
    logic [3:0]    drain_cnt, drain_cnt_next;
    logic [WW-1:0] wait_cnt, wait_cnt_next;
    logic          mem_timeout, mem_timeout_next;
    logic          mem_stall;
    logic          load_use;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                           input logic wen_m, input logic [4:0] rd_w,
                                           input logic wen_w);
        if (rs != 5'd0 && wen_m && rd_m == rs)
            return 2'b10;
        else if (rs != 5'd0 && wen_w && rd_w == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign mem_stall = (state != DRAIN) && hz.MEM_Req_M && !hz.MEM_Ready;
    assign load_use  = (hz.Result_Src_Sel_E == 2'b01) && (hz.RD_E != 5'd0) &&
                       ((hz.RD_E == hz.RS1_D) || (hz.RD_E == hz.RS2_D));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= DRAIN;
            drain_cnt   <= '0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            drain_cnt   <= drain_cnt_next;
            wait_cnt    <= wait_cnt_next;
            mem_timeout <= mem_timeout_next;
        end
    end

    // The wait counter counts consecutive stalled cycles; the first one loads 1 on entry.
    always_comb begin
        state_next       = state;
        drain_cnt_next   = drain_cnt;
        wait_cnt_next    = wait_cnt;
        mem_timeout_next = mem_timeout;
        case (state)
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_next     = RUN;
                    drain_cnt_next = '0;
                end else begin
                    drain_cnt_next = drain_cnt + 4'd1;
                end
            end
            RUN: begin
                if (mem_stall) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = WW'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_stall) begin
                    if (wait_cnt != WAIT_MAX)
                        wait_cnt_next = wait_cnt + WW'(1);
                end else begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end
            end
            default: state_next = DRAIN;
        endcase
        if (wait_cnt_next == WAIT_MAX)
            mem_timeout_next = 1'b1;
    end

    // Priority: drain, then memory stall, then taken branch, then load-use.
    always_comb begin
        hz.Stall_F = 1'b0;
        hz.Stall_D = 1'b0;
        hz.Stall_E = 1'b0;
        hz.Stall_M = 1'b0;
        hz.Flush_D = 1'b0;
        hz.Flush_E = 1'b0;
        hz.Flush_W = 1'b0;
        if (state == DRAIN) begin
            hz.Stall_F = 1'b1;
            hz.Flush_D = 1'b1;
            hz.Flush_E = 1'b1;
        end else if (mem_stall) begin
            hz.Stall_F = 1'b1;
            hz.Stall_D = 1'b1;
            hz.Stall_E = 1'b1;
            hz.Stall_M = 1'b1;
            hz.Flush_W = 1'b1;
        end else if (hz.PC_Src_Sel_E) begin
            hz.Flush_D = 1'b1;
            hz.Flush_E = 1'b1;
        end else if (load_use) begin
            hz.Stall_F = 1'b1;
            hz.Stall_D = 1'b1;
            hz.Flush_E = 1'b1;
        end
    end

    assign hz.Forward_A_E = fwd_sel(hz.RS1_E, hz.RD_M, hz.REG_W_En_M, hz.RD_W, hz.REG_W_En_W);
    assign hz.Forward_B_E = fwd_sel(hz.RS2_E, hz.RD_M, hz.REG_W_En_M, hz.RD_W, hz.REG_W_En_W);
    assign hz.Mem_Timeout = mem_timeout;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized scoreboard bench for hazard_control_unit: a driver pushes expected responses
// from a cycle-level reference model, a monitor pops and compares them every cycle.
module tb_hazard_control_unit;
    localparam int DRAIN_N = 2;
    localparam int WAIT_N  = 4;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
        logic [1:0] res_sel;
        logic       pcsrc;
        logic [4:0] rd_m;
        logic       wen_m;
        logic [4:0] rd_w;
        logic       wen_w;
        logic       req, ready;
    } stim_t;

    typedef struct packed {
        logic       stall_f, stall_d, stall_e, stall_m;
        logic       flush_d, flush_e, flush_w;
        logic [1:0] fwd_a, fwd_b;
        logic       timeout;
    } resp_t;

    logic CLK;
    logic RST;
    hazard_control_unit_if hif();

    hazard_control_unit #(.RESET_DRAIN_CYCLES(DRAIN_N), .MAX_WAIT_CYCLES(WAIT_N)) dut (
        .CLK(CLK),
        .RST(RST),
        .hz (hif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    resp_t sb[$];
    int    n_compared   = 0;
    int    n_mismatched = 0;
    int    cycle        = 0;

    // Reference model: cycles of drain still owed, consecutive stalled cycles, sticky timeout.
    int    drain_left  = DRAIN_N;
    int    wait_run    = 0;
    bit    timeout_ref = 1'b0;
    stim_t prev;

    function automatic logic [1:0] ref_fwd(input stim_t s, input logic [4:0] rs);
        if (rs == 0) return 2'd0;
        if (s.wen_m && s.rd_m == rs) return 2'd2;
        if (s.wen_w && s.rd_w == rs) return 2'd1;
        return 2'd0;
    endfunction

    function automatic resp_t ref_resp(input stim_t s);
        resp_t r;
        r = '0;
        r.fwd_a = ref_fwd(s, s.rs1_e);
        r.fwd_b = ref_fwd(s, s.rs2_e);
        r.timeout = s.rst ? 1'b0 : timeout_ref;
        if (s.rst || drain_left > 0) begin
            r.stall_f = 1; r.flush_d = 1; r.flush_e = 1;
        end else if (s.req && !s.ready) begin
            r.stall_f = 1; r.stall_d = 1; r.stall_e = 1; r.stall_m = 1; r.flush_w = 1;
        end else if (s.pcsrc) begin
            r.flush_d = 1; r.flush_e = 1;
        end else if (s.res_sel == 2'b01 && s.rd_e != 0 && (s.rd_e == s.rs1_d || s.rd_e == s.rs2_d)) begin
            r.stall_f = 1; r.stall_d = 1; r.flush_e = 1;
        end
        return r;
    endfunction

    task automatic advance_model(input stim_t s);
        if (s.rst) begin
            drain_left  = DRAIN_N;
            wait_run    = 0;
            timeout_ref = 1'b0;
        end else if (drain_left > 0) begin
            drain_left--;
        end else if (s.req && !s.ready) begin
            if (wait_run < WAIT_N) wait_run++;
            if (wait_run >= WAIT_N) timeout_ref = 1'b1;
        end else begin
            wait_run = 0;
        end
    endtask

    task automatic apply_stimulus(input stim_t s);
        @(posedge CLK);
        #1;
        advance_model(prev);
        RST                  = s.rst;
        hif.RS1_D            = s.rs1_d;
        hif.RS2_D            = s.rs2_d;
        hif.RS1_E            = s.rs1_e;
        hif.RS2_E            = s.rs2_e;
        hif.RD_E             = s.rd_e;
        hif.Result_Src_Sel_E = s.res_sel;
        hif.PC_Src_Sel_E     = s.pcsrc;
        hif.RD_M             = s.rd_m;
        hif.REG_W_En_M       = s.wen_m;
        hif.RD_W             = s.rd_w;
        hif.REG_W_En_W       = s.wen_w;
        hif.MEM_Req_M        = s.req;
        hif.MEM_Ready        = s.ready;
        sb.push_back(ref_resp(s));
        prev = s;
    endtask

    task automatic check_output(input resp_t got, input resp_t exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL outputs cycle=%0d got sF%b sD%b sE%b sM%b fD%b fE%b fW%b fa%b fb%b to%b required sF%b sD%b sE%b sM%b fD%b fE%b fW%b fa%b fb%b to%b",
                     cycle, got.stall_f, got.stall_d, got.stall_e, got.stall_m, got.flush_d,
                     got.flush_e, got.flush_w, got.fwd_a, got.fwd_b, got.timeout,
                     exp.stall_f, exp.stall_d, exp.stall_e, exp.stall_m, exp.flush_d,
                     exp.flush_e, exp.flush_w, exp.fwd_a, exp.fwd_b, exp.timeout);
        end
    endtask

    // Monitor: the DUT presents a full response every cycle; sample mid-cycle.
    always @(negedge CLK) begin
        resp_t got;
        cycle++;
        if (sb.size() > 0) begin
            got = '{hif.Stall_F, hif.Stall_D, hif.Stall_E, hif.Stall_M, hif.Flush_D,
                    hif.Flush_E, hif.Flush_W, hif.Forward_A_E, hif.Forward_B_E, hif.Mem_Timeout};
            check_output(got, sb.pop_front());
        end
    end

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst     = ($urandom_range(0, 99) == 0);
        s.rs1_d   = 5'($urandom_range(0, 3));
        s.rs2_d   = 5'($urandom_range(0, 3));
        s.rs1_e   = 5'($urandom_range(0, 3));
        s.rs2_e   = 5'($urandom_range(0, 3));
        s.rd_e    = 5'($urandom_range(0, 3));
        s.res_sel = 2'($urandom_range(0, 3));
        s.pcsrc   = ($urandom_range(0, 4) == 0);
        s.rd_m    = 5'($urandom_range(0, 3));
        s.wen_m   = 1'($urandom_range(0, 1));
        s.rd_w    = 5'($urandom_range(0, 3));
        s.wen_w   = 1'($urandom_range(0, 1));
        s.req     = ($urandom_range(0, 2) == 0);
        s.ready   = ($urandom_range(0, 3) == 0);
        return s;
    endfunction

    initial begin
        stim_t s;
        prev = '0;
        prev.rst = 1'b1;
        RST = 1'b1;
        hif.RS1_D = '0; hif.RS2_D = '0; hif.RS1_E = '0; hif.RS2_E = '0; hif.RD_E = '0;
        hif.Result_Src_Sel_E = '0; hif.PC_Src_Sel_E = 1'b0; hif.RD_M = '0;
        hif.REG_W_En_M = 1'b0; hif.RD_W = '0; hif.REG_W_En_W = 1'b0;
        hif.MEM_Req_M = 1'b0; hif.MEM_Ready = 1'b0;

        // Reset held two cycles, then the drain window and idle run.
        s = '0; s.rst = 1'b1;
        repeat (2) apply_stimulus(s);
        s = '0;
        repeat (4) apply_stimulus(s);

        // Forwarding: memory wins, writeback fallback, x0 never forwarded.
        s = '0; s.rs1_e = 5; s.rd_m = 5; s.wen_m = 1; s.rd_w = 5; s.wen_w = 1;
        apply_stimulus(s);
        s.wen_m = 0;
        apply_stimulus(s);
        s = '0; s.rs2_e = 0; s.rd_m = 0; s.wen_m = 1;
        apply_stimulus(s);

        // Load-use, then with x0 destination, then with a simultaneous taken branch.
        s = '0; s.res_sel = 2'b01; s.rd_e = 7; s.rs2_d = 7;
        apply_stimulus(s);
        s.rd_e = 0;
        apply_stimulus(s);
        s.rd_e = 7; s.pcsrc = 1;
        apply_stimulus(s);

        // Three-cycle memory wait with a branch pending, then release.
        s = '0; s.req = 1; s.ready = 0; s.pcsrc = 1;
        repeat (3) apply_stimulus(s);
        s.ready = 1; s.pcsrc = 0;
        apply_stimulus(s);

        // Long wait crosses the timeout, then reset lands mid-wait.
        s = '0; s.req = 1; s.ready = 0;
        repeat (6) apply_stimulus(s);
        s.rst = 1;
        apply_stimulus(s);
        s = '0;
        repeat (4) apply_stimulus(s);

        for (int i = 0; i < 3000; i++)
            apply_stimulus(rand_stim());

        @(negedge CLK);
        #1;
        n_compared++;
        if (sb.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL scoreboard_drain got %0d pending required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
